// File: rtl/frame_hit_resolver_pkg.sv
// Shared widths, player-state encodings and judge FSM states for the frame hit resolver.
// body_gap() gives the free space between the two bodies, clamped to 0 on overlap.
package frame_hit_resolver_pkg;

    localparam int unsigned STATE_DEPTH        = 3;
    localparam int unsigned SPRITE_INDEX_DEPTH = 3;
    localparam int unsigned POSITION_DEPTH     = 10;
    localparam int unsigned PLAYER_WIDTH       = 64;
    localparam int unsigned GAP_W              = POSITION_DEPTH + 1;

    typedef enum logic [STATE_DEPTH-1:0] {
        NOTHING       = 3'd0,
        WALK_FORWARD  = 3'd1,
        WALK_BACKWARD = 3'd2,
        BLOCK         = 3'd3,
        KICK          = 3'd4,
        GRAB          = 3'd5,
        WIN           = 3'd6,
        LOSE          = 3'd7
    } player_state_e;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_DONE  = 3'd1,
        EVAL       = 3'd2,
        UPDATE     = 3'd3,
        ROUND_OVER = 3'd4
    } judge_state_e;

    function automatic logic [GAP_W-1:0] body_gap(
        input logic [POSITION_DEPTH-1:0] left_x,
        input logic [POSITION_DEPTH-1:0] right_x
    );
        logic [GAP_W-1:0] near_edge;
        near_edge = {1'b0, left_x} + GAP_W'(PLAYER_WIDTH);
        if ({1'b0, right_x} < near_edge) begin
            return '0;
        end
        return {1'b0, right_x} - near_edge;
    endfunction

endpackage

// File: rtl/frame_hit_resolver_if.sv
// Player-side bundle of the hit resolver: both players' frame outputs in, judgement out.
interface frame_hit_resolver_if;
    import frame_hit_resolver_pkg::*;

    logic                          frame_clk;
    logic [STATE_DEPTH-1:0]        p1_state;
    logic [STATE_DEPTH-1:0]        p2_state;
    logic [SPRITE_INDEX_DEPTH-1:0] p1_index;
    logic [SPRITE_INDEX_DEPTH-1:0] p2_index;
    logic [POSITION_DEPTH-1:0]     p1_position;
    logic [POSITION_DEPTH-1:0]     p2_position;
    logic                          p1_done;
    logic                          p2_done;
    logic                          p1_attack_connected;
    logic                          p2_attack_connected;
    logic                          round_over;
    logic                          eval_valid;
    logic                          timeout_err;

    modport master (
        output frame_clk, p1_state, p2_state, p1_index, p2_index,
               p1_position, p2_position, p1_done, p2_done,
        input  p1_attack_connected, p2_attack_connected, round_over,
               eval_valid, timeout_err
    );

    modport slave (
        input  frame_clk, p1_state, p2_state, p1_index, p2_index,
               p1_position, p2_position, p1_done, p2_done,
        output p1_attack_connected, p2_attack_connected, round_over,
               eval_valid, timeout_err
    );

endinterface

// File: rtl/frame_hit_resolver_edge.sv
// Registered rising-edge detector: one-cycle pulse, one cycle after the input is sampled high.
module rising_edge_detector (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= i_sig & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/frame_hit_resolver_reach.sv
// Whether one attacker's kick or grab physically reaches the defender this frame.
// A defender already in WIN/LOSE can never be reached.
module attack_reach_check
    import frame_hit_resolver_pkg::*;
#(
    parameter int unsigned KICK_RANGE        = 40,
    parameter int unsigned GRAB_RANGE        = 16,
    parameter int unsigned KICK_ACTIVE_START = 2,
    parameter int unsigned KICK_ACTIVE_END   = 3,
    parameter int unsigned GRAB_ACTIVE       = 2
) (
    input  logic [STATE_DEPTH-1:0]        i_att_state,
    input  logic [SPRITE_INDEX_DEPTH-1:0] i_att_index,
    input  logic [STATE_DEPTH-1:0]        i_def_state,
    input  logic [GAP_W-1:0]              i_gap,
    output logic                          o_kick_hit,
    output logic                          o_grab_hit
);

    localparam logic [SPRITE_INDEX_DEPTH-1:0] L_KICK_LO = SPRITE_INDEX_DEPTH'(KICK_ACTIVE_START);
    localparam logic [SPRITE_INDEX_DEPTH-1:0] L_KICK_HI = SPRITE_INDEX_DEPTH'(KICK_ACTIVE_END);
    localparam logic [SPRITE_INDEX_DEPTH-1:0] L_GRAB_AT = SPRITE_INDEX_DEPTH'(GRAB_ACTIVE);
    localparam logic [GAP_W-1:0]              L_KICK_RG = GAP_W'(KICK_RANGE);
    localparam logic [GAP_W-1:0]              L_GRAB_RG = GAP_W'(GRAB_RANGE);

    logic w_hittable;

    always_comb begin
        w_hittable = (i_def_state != WIN) && (i_def_state != LOSE);
        o_kick_hit = w_hittable && (i_att_state == KICK)
                     && (i_att_index >= L_KICK_LO) && (i_att_index <= L_KICK_HI)
                     && (i_gap <= L_KICK_RG);
        o_grab_hit = w_hittable && (i_att_state == GRAB)
                     && (i_att_index == L_GRAB_AT)
                     && (i_gap <= L_GRAB_RG);
    end

endmodule

// File: rtl/frame_hit_resolver.sv
// Per-frame judge: waits for both players' done flags, decides who connected,
// and latches the round result until reset.
module frame_hit_resolver
    import frame_hit_resolver_pkg::*;
#(
    parameter int unsigned KICK_RANGE        = 40,
    parameter int unsigned GRAB_RANGE        = 16,
    parameter int unsigned KICK_ACTIVE_START = 2,
    parameter int unsigned KICK_ACTIVE_END   = 3,
    parameter int unsigned GRAB_ACTIVE       = 2,
    parameter int unsigned DONE_TIMEOUT      = 15
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    frame_hit_resolver_if.slave  bus
);

    localparam int unsigned WAIT_W = $clog2(DONE_TIMEOUT + 1);

    judge_state_e r_state;
    judge_state_e w_next;

    logic                          w_frame_edge;
    logic                          w_capture;
    logic                          w_commit;
    logic                          w_timeout;
    logic [WAIT_W-1:0]             r_wait;
    logic [STATE_DEPTH-1:0]        r_p1_state;
    logic [STATE_DEPTH-1:0]        r_p2_state;
    logic [SPRITE_INDEX_DEPTH-1:0] r_p1_index;
    logic [SPRITE_INDEX_DEPTH-1:0] r_p2_index;
    logic [POSITION_DEPTH-1:0]     r_p1_pos;
    logic [POSITION_DEPTH-1:0]     r_p2_pos;
    logic [GAP_W-1:0]              w_gap;
    logic                          w_p1_kick;
    logic                          w_p1_grab;
    logic                          w_p2_kick;
    logic                          w_p2_grab;
    logic                          w_p1_conn;
    logic                          w_p2_conn;
    logic                          r_p1_conn;
    logic                          r_p2_conn;
    logic                          r_round_over;
    logic                          r_eval_valid;
    logic                          r_timeout;

    rising_edge_detector u_frame_edge (
        .i_clk  (sys_clk),
        .i_rst  (reset),
        .i_sig  (bus.frame_clk),
        .o_rise (w_frame_edge)
    );

    assign w_gap = body_gap(r_p1_pos, r_p2_pos);

    attack_reach_check #(
        .KICK_RANGE        (KICK_RANGE),
        .GRAB_RANGE        (GRAB_RANGE),
        .KICK_ACTIVE_START (KICK_ACTIVE_START),
        .KICK_ACTIVE_END   (KICK_ACTIVE_END),
        .GRAB_ACTIVE       (GRAB_ACTIVE)
    ) u_reach_p1 (
        .i_att_state (r_p1_state),
        .i_att_index (r_p1_index),
        .i_def_state (r_p2_state),
        .i_gap       (w_gap),
        .o_kick_hit  (w_p1_kick),
        .o_grab_hit  (w_p1_grab)
    );

    attack_reach_check #(
        .KICK_RANGE        (KICK_RANGE),
        .GRAB_RANGE        (GRAB_RANGE),
        .KICK_ACTIVE_START (KICK_ACTIVE_START),
        .KICK_ACTIVE_END   (KICK_ACTIVE_END),
        .GRAB_ACTIVE       (GRAB_ACTIVE)
    ) u_reach_p2 (
        .i_att_state (r_p2_state),
        .i_att_index (r_p2_index),
        .i_def_state (r_p1_state),
        .i_gap       (w_gap),
        .o_kick_hit  (w_p2_kick),
        .o_grab_hit  (w_p2_grab)
    );

    // Block stops kicks only; a landing kick cancels the opponent's grab.
    assign w_p1_conn = (w_p1_kick && (r_p2_state != BLOCK)) || (w_p1_grab && !w_p2_kick);
    assign w_p2_conn = (w_p2_kick && (r_p1_state != BLOCK)) || (w_p2_grab && !w_p1_kick);

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_commit  = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_frame_edge) w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.p1_done && bus.p2_done) begin
                    w_next    = EVAL;
                    w_capture = 1'b1;
                end else if (r_wait == WAIT_W'(DONE_TIMEOUT - 1)) begin
                    w_next    = IDLE;
                    w_timeout = 1'b1;
                end
            end
            EVAL: begin
                w_next   = UPDATE;
                w_commit = 1'b1;
            end
            UPDATE: begin
                w_next = r_round_over ? ROUND_OVER : IDLE;
            end
            ROUND_OVER: w_next = ROUND_OVER;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (r_state == WAIT_DONE) ? r_wait + 1'b1 : '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_p1_state <= '0;
            r_p2_state <= '0;
            r_p1_index <= '0;
            r_p2_index <= '0;
            r_p1_pos   <= '0;
            r_p2_pos   <= '0;
        end else if (w_capture) begin
            r_p1_state <= bus.p1_state;
            r_p2_state <= bus.p2_state;
            r_p1_index <= bus.p1_index;
            r_p2_index <= bus.p2_index;
            r_p1_pos   <= bus.p1_position;
            r_p2_pos   <= bus.p2_position;
        end
    end

    // Inputs are captured on entry to EVAL so the result lands as UPDATE begins,
    // keeping eval_valid two cycles after the done flags are seen.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_p1_conn    <= 1'b0;
            r_p2_conn    <= 1'b0;
            r_round_over <= 1'b0;
            r_eval_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_eval_valid <= w_commit;
            if (w_timeout) r_timeout <= 1'b1;
            if (w_commit && (w_p1_conn ^ w_p2_conn)) begin
                r_p1_conn    <= w_p1_conn;
                r_p2_conn    <= w_p2_conn;
                r_round_over <= 1'b1;
            end
        end
    end

    assign bus.p1_attack_connected = r_p1_conn;
    assign bus.p2_attack_connected = r_p2_conn;
    assign bus.round_over          = r_round_over;
    assign bus.eval_valid          = r_eval_valid;
    assign bus.timeout_err         = r_timeout;

endmodule

// File: tb/tb_frame_hit_resolver.sv
// Directed and randomized frames for frame_hit_resolver, checked against a rule-level model.
module tb_frame_hit_resolver;
    import frame_hit_resolver_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   exp_p1 = 0, exp_p2 = 0, exp_ro = 0, exp_to = 0;

    frame_hit_resolver_if bus ();

    frame_hit_resolver #(
        .KICK_RANGE        (40),
        .GRAB_RANGE        (16),
        .KICK_ACTIVE_START (2),
        .KICK_ACTIVE_END   (3),
        .GRAB_ACTIVE       (2),
        .DONE_TIMEOUT      (15)
    ) dut (
        .sys_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_p1"}, bus.p1_attack_connected, exp_p1);
        chk({tag, "_p2"}, bus.p2_attack_connected, exp_p2);
        chk({tag, "_ro"}, bus.round_over, exp_ro);
        chk({tag, "_to"}, bus.timeout_err, exp_to);
    endtask

    // Reference: judge one frame from the game rules using plain integer distances.
    function automatic void judge(input int s1, i1, p1, s2, i2, p2, output bit c1, output bit c2);
        int  gap;
        bit  k1, g1, k2, g2, hit1ok, hit2ok;
        gap    = p2 - p1 - 64;
        if (gap < 0) gap = 0;
        hit1ok = !(s2 == int'(WIN) || s2 == int'(LOSE));
        hit2ok = !(s1 == int'(WIN) || s1 == int'(LOSE));
        k1 = hit1ok && s1 == int'(KICK) && i1 >= 2 && i1 <= 3 && gap <= 40;
        g1 = hit1ok && s1 == int'(GRAB) && i1 == 2 && gap <= 16;
        k2 = hit2ok && s2 == int'(KICK) && i2 >= 2 && i2 <= 3 && gap <= 40;
        g2 = hit2ok && s2 == int'(GRAB) && i2 == 2 && gap <= 16;
        c1 = (k1 && s2 != int'(BLOCK)) || (g1 && !k2);
        c2 = (k2 && s1 != int'(BLOCK)) || (g2 && !k1);
    endfunction

    task automatic drive_players(input int s1, i1, p1, s2, i2, p2);
        bus.p1_state    = STATE_DEPTH'(s1);
        bus.p1_index    = SPRITE_INDEX_DEPTH'(i1);
        bus.p1_position = POSITION_DEPTH'(p1);
        bus.p2_state    = STATE_DEPTH'(s2);
        bus.p2_index    = SPRITE_INDEX_DEPTH'(i2);
        bus.p2_position = POSITION_DEPTH'(p2);
    endtask

    task automatic frame_pulse();
        bus.frame_clk = 1'b1;
        tick();
        bus.frame_clk = 1'b0;
        tick(3);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick(2);
        exp_p1 = 0; exp_p2 = 0; exp_ro = 0; exp_to = 0;
        chk_outputs(tag);
        chk({tag, "_ev"}, bus.eval_valid, 1'b0);
        rst = 1'b0;
        tick();
    endtask

    task automatic run_frame(input string tag, input int s1, i1, p1, s2, i2, p2);
        bit c1, c2, will_eval;
        judge(s1, i1, p1, s2, i2, p2, c1, c2);
        will_eval = !exp_ro;
        drive_players(s1, i1, p1, s2, i2, p2);
        frame_pulse();
        bus.p1_done = 1'b1;
        bus.p2_done = 1'b1;
        tick();
        chk({tag, "_ev_early"}, bus.eval_valid, 1'b0);
        tick();
        if (will_eval && (c1 ^ c2)) begin
            exp_p1 = c1; exp_p2 = c2; exp_ro = 1;
        end
        chk({tag, "_ev"}, bus.eval_valid, will_eval);
        chk_outputs(tag);
        bus.p1_done = 1'b0;
        bus.p2_done = 1'b0;
        tick();
        chk({tag, "_ev_end"}, bus.eval_valid, 1'b0);
        tick(2);
    endtask

    task automatic run_timeout(input string tag);
        bit saw_eval;
        saw_eval = 0;
        drive_players(int'(KICK), 2, 100, int'(NOTHING), 0, 150);
        frame_pulse();
        bus.p1_done = 1'b1;
        bus.p2_done = 1'b0;
        for (int k = 0; k < 22; k++) begin
            if (k == 6) chk({tag, "_early"}, bus.timeout_err, 1'b0);
            if (bus.eval_valid) saw_eval = 1;
            tick();
        end
        exp_to = 1;
        chk({tag, "_noeval"}, saw_eval, 1'b0);
        chk_outputs(tag);
        bus.p1_done = 1'b0;
        tick(2);
    endtask

    task automatic run_reset_in_eval(input string tag);
        drive_players(int'(KICK), 2, 100, int'(NOTHING), 0, 204);
        frame_pulse();
        bus.p1_done = 1'b1;
        bus.p2_done = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        exp_p1 = 0; exp_p2 = 0; exp_ro = 0; exp_to = 0;
        chk_outputs(tag);
        chk({tag, "_ev"}, bus.eval_valid, 1'b0);
        rst = 1'b0;
        bus.p1_done = 1'b0;
        bus.p2_done = 1'b0;
        tick();
        chk({tag, "_ev_after"}, bus.eval_valid, 1'b0);
        tick(2);
    endtask

    initial begin
        int pick [8];
        int s1, s2, i1, i2, p1, p2;
        pick = '{int'(NOTHING), int'(BLOCK), int'(KICK), int'(GRAB),
                 int'(KICK), int'(GRAB), int'(WIN), int'(WALK_FORWARD)};

        bus.frame_clk = 1'b0;
        bus.p1_done   = 1'b0;
        bus.p2_done   = 1'b0;
        drive_players(0, 0, 100, 0, 0, 300);
        tick(2);
        do_reset("reset");

        run_frame("gap41",      int'(KICK), 2, 100, int'(NOTHING), 0, 205);
        run_frame("kick_block", int'(KICK), 3, 100, int'(BLOCK),   0, 174);
        run_frame("trade_kick", int'(KICK), 2, 100, int'(KICK),    2, 164);
        run_frame("win_immune", int'(KICK), 2, 100, int'(WIN),     0, 170);
        run_timeout("timeout");
        run_reset_in_eval("rst_eval");

        run_frame("gap40",      int'(KICK), 2, 100, int'(NOTHING), 0, 204);
        run_frame("hold_ro",    int'(NOTHING), 0, 100, int'(KICK), 2, 170);
        run_frame("hold_ro2",   int'(GRAB), 2, 100, int'(GRAB),    2, 170);
        do_reset("reset2");

        run_frame("grab_block", int'(GRAB), 2, 100, int'(BLOCK),   0, 174);
        do_reset("reset3");
        run_frame("kick_beats_grab", int'(GRAB), 2, 100, int'(KICK), 2, 169);
        do_reset("reset4");
        run_frame("overlap",    int'(KICK), 2, 100, int'(NOTHING), 0, 150);
        do_reset("reset5");

        for (int n = 0; n < 40; n++) begin
            s1 = pick[$urandom_range(0, 7)];
            s2 = pick[$urandom_range(0, 7)];
            i1 = $urandom_range(0, 4);
            i2 = $urandom_range(0, 4);
            p1 = $urandom_range(0, 400);
            if ($urandom_range(0, 7) == 0) p2 = $urandom_range(0, p1);
            else                           p2 = p1 + $urandom_range(40, 130);
            run_frame("rand", s1, i1, p1, s2, i2, p2);
            if (exp_ro && $urandom_range(0, 1) == 1) do_reset("rand_reset");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
